// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier.
//
// Takes one Booth step per clock. The full-width signed product appears on p
// together with a one-cycle done pulse, WIDTH cycles after the operands are
// captured.
//
// Ports:
//   clk    system clock; all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   start  operation request; sampled only while idle
//   a      multiplicand, two's complement; captured on an accepted start
//   b      multiplier, two's complement; captured on an accepted start
//   busy   high while the Booth iteration is running
//   done   one-cycle pulse; p holds the product of the new operands
//   p      signed product, 2*WIDTH bits; holds until the next completion
module booth_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    // The accumulator and multiplicand are one bit wider than the operands so
    // that negating -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   q_sh;

    // One Booth step: add/subtract on the recoded bit pair, then an arithmetic
    // right shift of {acc, q, q1}.
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh   = {sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        p_d     = p_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = {a[WIDTH-1], a};
                    q_d     = b;
                    q1_d    = 1'b0;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d   = acc_sh;
                q_d     = q_sh;
                q1_d    = q_q[0];
                count_d = count_q + 1'b1;
                if (count_q == CntW'(WIDTH - 1)) begin
                    p_d     = {acc_sh[WIDTH-1:0], q_sh};
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flags are registered from the next state so outputs come straight
        // from flops.
        busy_d = (state_d == StCalc);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
